// File: rtl/t2mi_ts_extractor.sv
// T2-MI extractor: filters a 188-byte TS stream on t2mi_pid, strips header,
// adaptation field and pointer, checks continuity and emits the T2-MI bytes.
module t2mi_ts_extractor #(
  parameter logic [7:0]  SYNC_BYTE = 8'h47,
  parameter int unsigned TS_LEN    = 188
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [7:0]  DATA_IN,
  input  logic        ENA_IN,
  input  logic        PSYNC_IN,
  input  logic [12:0] t2mi_pid,
  output logic [7:0]  DATA_OUT,
  output logic        ENA_OUT,
  output logic        START_OUT,
  output logic        CC_ERR,
  output logic        SYNC_ERR,
  output logic [3:0]  state_mon
);

  typedef enum logic [3:0] {
    WAIT_SYNC = 4'd0,
    HDR       = 4'd1,
    AF_LEN    = 4'd2,
    AF_SKIP   = 4'd3,
    POINTER   = 4'd4,
    PAYLOAD   = 4'd5,
    SKIP      = 4'd6
  } state_t;

  localparam logic [7:0] LAST_POS = 8'(TS_LEN - 1);
  // Largest adaptation field that still leaves one payload byte.
  localparam logic [7:0] AF_MAX   = 8'(TS_LEN - 6);

  state_t      state, next_state;
  logic [7:0]  pos;
  logic        tei, pusi, pid_match;
  logic [4:0]  pid_hi;
  logic [1:0]  afc;
  logic [3:0]  last_cc;
  logic        cc_valid, locked, expect_sync;
  logic [7:0]  af_cnt, ptr, off;
  logic [7:0]  remain;
  logic        last_byte;
  logic        emit, emit_start, cc_check, cc_bad, sync_bad;

  assign remain    = LAST_POS - pos;
  assign last_byte = (pos == LAST_POS);
  assign state_mon = state;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state <= WAIT_SYNC;
    else      state <= next_state;
  end

  always_comb begin
    next_state = state;
    if (ENA_IN) begin
      if (PSYNC_IN) begin
        next_state = (DATA_IN == SYNC_BYTE) ? HDR : WAIT_SYNC;
      end else if (state != WAIT_SYNC) begin
        case (state)
          HDR: begin
            if (pos == 8'd3) begin
              if (!pid_match || tei || DATA_IN[7:6] != 2'b00 || DATA_IN[5:4] == 2'b00)
                next_state = SKIP;
              else if (DATA_IN[5])
                next_state = AF_LEN;
              else
                next_state = pusi ? POINTER : PAYLOAD;
            end
          end
          AF_LEN: begin
            if ((afc == 2'b11 && DATA_IN > AF_MAX) || afc == 2'b10)
              next_state = SKIP;
            else if (DATA_IN == 8'd0)
              next_state = pusi ? POINTER : PAYLOAD;
            else
              next_state = AF_SKIP;
          end
          AF_SKIP: if (af_cnt == 8'd1) next_state = pusi ? POINTER : PAYLOAD;
          POINTER: next_state = (DATA_IN >= remain) ? SKIP : PAYLOAD;
          default: next_state = state;
        endcase
        // Whatever the state, the packet ends on its last byte.
        if (last_byte) next_state = WAIT_SYNC;
      end
    end
  end

  always_comb begin
    emit       = 1'b0;
    emit_start = 1'b0;
    cc_check   = 1'b0;
    cc_bad     = 1'b0;
    sync_bad   = 1'b0;
    if (ENA_IN) begin
      if (PSYNC_IN) begin
        sync_bad = (DATA_IN != SYNC_BYTE) || (state != WAIT_SYNC);
      end else if (state == WAIT_SYNC) begin
        sync_bad = expect_sync;
      end else begin
        if (state == HDR && pos == 8'd3) begin
          cc_check = pid_match && DATA_IN[4] && !tei;
          cc_bad   = cc_check && cc_valid && (DATA_IN[3:0] != last_cc + 4'd1);
        end
        if (state == PAYLOAD) begin
          emit_start = pusi && (off == ptr);
          emit       = locked || (pusi && off >= ptr);
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      DATA_OUT    <= '0;
      ENA_OUT     <= 1'b0;
      START_OUT   <= 1'b0;
      CC_ERR      <= 1'b0;
      SYNC_ERR    <= 1'b0;
      pos         <= '0;
      tei         <= 1'b0;
      pusi        <= 1'b0;
      pid_hi      <= '0;
      pid_match   <= 1'b0;
      afc         <= '0;
      last_cc     <= '0;
      cc_valid    <= 1'b0;
      locked      <= 1'b0;
      expect_sync <= 1'b0;
      af_cnt      <= '0;
      ptr         <= '0;
      off         <= '0;
    end else begin
      ENA_OUT   <= emit;
      START_OUT <= emit_start;
      CC_ERR    <= cc_bad;
      SYNC_ERR  <= sync_bad;
      if (emit) DATA_OUT <= DATA_IN;
      if (ENA_IN) begin
        if (PSYNC_IN) begin
          pos         <= (DATA_IN == SYNC_BYTE) ? 8'd1 : 8'd0;
          expect_sync <= 1'b0;
          if (sync_bad) locked <= 1'b0;
        end else if (state == WAIT_SYNC) begin
          expect_sync <= 1'b0;
        end else begin
          pos         <= last_byte ? 8'd0 : pos + 8'd1;
          expect_sync <= last_byte;
          case (state)
            HDR: begin
              case (pos)
                8'd1: begin
                  tei    <= DATA_IN[7];
                  pusi   <= DATA_IN[6];
                  pid_hi <= DATA_IN[4:0];
                end
                8'd2: pid_match <= ({pid_hi, DATA_IN} == t2mi_pid);
                8'd3: begin
                  afc <= DATA_IN[5:4];
                  if (tei) locked <= 1'b0;
                  if (cc_check) begin
                    cc_valid <= 1'b1;
                    last_cc  <= DATA_IN[3:0];
                  end
                  if (cc_bad) locked <= 1'b0;
                end
                default: ;
              endcase
            end
            AF_LEN: begin
              af_cnt <= DATA_IN;
              if (afc == 2'b11 && DATA_IN > AF_MAX) locked <= 1'b0;
            end
            AF_SKIP: af_cnt <= af_cnt - 8'd1;
            POINTER: begin
              ptr <= DATA_IN;
              off <= '0;
              if (DATA_IN >= remain) locked <= 1'b0;
            end
            PAYLOAD: begin
              off <= off + 8'd1;
              if (emit_start) locked <= 1'b1;
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_t2mi_ts_extractor.sv
// Directed bench for t2mi_ts_extractor: packets are driven byte by byte, the
// expected output bytes are queued and a monitor checks them as they appear.
module tb_t2mi_ts_extractor;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [7:0]  DATA_IN = '0;
  logic        ENA_IN = 1'b0;
  logic        PSYNC_IN = 1'b0;
  logic [12:0] t2mi_pid = 13'h1000;
  logic [7:0]  DATA_OUT;
  logic        ENA_OUT, START_OUT, CC_ERR, SYNC_ERR;
  logic [3:0]  state_mon;

  t2mi_ts_extractor #(.SYNC_BYTE(8'h47), .TS_LEN(188)) dut (
    .CLK(CLK), .RST(RST), .DATA_IN(DATA_IN), .ENA_IN(ENA_IN), .PSYNC_IN(PSYNC_IN),
    .t2mi_pid(t2mi_pid), .DATA_OUT(DATA_OUT), .ENA_OUT(ENA_OUT), .START_OUT(START_OUT),
    .CC_ERR(CC_ERR), .SYNC_ERR(SYNC_ERR), .state_mon(state_mon)
  );

  always #5 CLK = ~CLK;

  typedef struct { logic [7:0] d; bit st; int cy; } exp_t;
  exp_t sbq[$];

  int checks = 0, errors = 0;
  int cyc = 0, hdr3_cyc = 0;
  int cc_cnt = 0, se_cnt = 0, start_cnt = 0, cc_err_cyc = -1;

  always @(posedge CLK) cyc++;

  always @(negedge CLK) begin
    exp_t e;
    if (CC_ERR) begin cc_cnt++; cc_err_cyc = cyc; end
    if (SYNC_ERR) se_cnt++;
    if (ENA_OUT) begin
      if (START_OUT) start_cnt++;
      checks++;
      if (sbq.size() == 0) begin
        errors++;
        $display("FAIL unexpected_out actual data=%h start=%0b required no output (cyc %0d)",
                 DATA_OUT, START_OUT, cyc);
      end else begin
        e = sbq.pop_front();
        if (DATA_OUT !== e.d || START_OUT !== e.st || cyc != e.cy) begin
          errors++;
          $display("FAIL out_byte actual data=%h start=%0b cyc=%0d required data=%h start=%0b cyc=%0d",
                   DATA_OUT, START_OUT, cyc, e.d, e.st, e.cy);
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic put(input logic [7:0] d, input bit ps, input bit exp_out, input bit st);
    exp_t e;
    @(negedge CLK);
    DATA_IN = d; PSYNC_IN = ps; ENA_IN = 1'b1;
    if (exp_out) begin
      e.d = d; e.st = st; e.cy = cyc + 1;
      sbq.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge CLK);
      ENA_IN = 1'b0; PSYNC_IN = 1'b0;
    end
  endtask

  // Bytes 0..3 header, byte 4 pointer/af_len, idx2 overrides one later byte.
  task automatic send_pkt(input logic [12:0] pid, input bit pusi, input logic [1:0] afc,
                          input logic [3:0] cc, input logic [7:0] b4, input int idx2,
                          input logic [7:0] v2, input int len, input int out_from,
                          input int start_at, input bit gaps, input logic [7:0] seed);
    logic [7:0] b;
    for (int i = 0; i < len; i++) begin
      case (i)
        0: b = 8'h47;
        1: b = {1'b0, pusi, 1'b0, pid[12:8]};
        2: b = pid[7:0];
        3: b = {2'b00, afc, cc};
        4: b = b4;
        default: b = 8'((i * 13) + int'(seed));
      endcase
      if (i == idx2) b = v2;
      put(b, i == 0, i >= out_from, i == start_at);
      if (i == 3) hdr3_cyc = cyc + 1;
      if (gaps && (i % 10 == 9) && i < len - 1) idle(i % 3 + 1);
    end
  endtask

  task automatic drain(input string name);
    idle(2);
    #1;
    chk(name, sbq.size(), 0);
  endtask

  initial begin
    #1 RST = 1'b0;
    #3;
    chk("rst_data", int'(DATA_OUT), 0);
    chk("rst_ena", int'(ENA_OUT), 0);
    chk("rst_start", int'(START_OUT), 0);
    chk("rst_ccerr", int'(CC_ERR), 0);
    chk("rst_syncerr", int'(SYNC_ERR), 0);
    chk("rst_state", int'(state_mon), 0);
    idle(2);
    RST = 1'b1;
    idle(2);

    // First packet: ptr=10, not locked, 173 bytes from the start byte.
    send_pkt(13'h1000, 1, 2'b01, 4'd0, 8'd10, -1, 8'h00, 188, 15, 15, 0, 8'h11);
    drain("p1_drain");
    chk("p1_ccerr", cc_cnt, 0);
    chk("p1_starts", start_cnt, 1);

    // Continuation packet with input gaps, all 184 bytes out.
    send_pkt(13'h1000, 0, 2'b01, 4'd1, 8'hA5, -1, 8'h00, 188, 4, -1, 1, 8'h22);
    drain("p2_drain");
    chk("p2_starts", start_cnt, 1);

    // CC jump 1->3 with PUSI: error pulse, continuation suppressed.
    send_pkt(13'h1000, 1, 2'b01, 4'd3, 8'd20, -1, 8'h00, 188, 25, 25, 0, 8'h33);
    drain("p3_drain");
    chk("p3_ccerr_cnt", cc_cnt, 1);
    chk("p3_ccerr_cyc", cc_err_cyc, hdr3_cyc);

    // AFC=11 with empty adaptation field.
    send_pkt(13'h1000, 0, 2'b11, 4'd4, 8'd0, -1, 8'h00, 188, 5, -1, 0, 8'h44);
    drain("p4_drain");

    // AFC=11, 10 adaptation bytes, pointer at byte 15 = 3, start at byte 19.
    send_pkt(13'h1000, 1, 2'b11, 4'd5, 8'd10, 15, 8'd3, 188, 16, 19, 0, 8'h55);
    drain("p4b_drain");
    chk("p4b_starts", start_cnt, 3);

    // AFC=10, af_len=183: nothing out, CC neither checked nor advanced.
    send_pkt(13'h1000, 0, 2'b10, 4'd6, 8'd183, -1, 8'h00, 188, 188, -1, 0, 8'h66);
    drain("p5_drain");
    send_pkt(13'h1000, 0, 2'b01, 4'd6, 8'h5A, -1, 8'h00, 188, 4, -1, 0, 8'h77);
    drain("p6_drain");
    chk("p6_ccerr_cnt", cc_cnt, 1);

    // Foreign PID gives no output.
    send_pkt(13'h0000, 1, 2'b01, 4'd9, 8'd0, -1, 8'h00, 188, 188, -1, 0, 8'h88);
    drain("p7_drain");

    // T2-MI packet cut at pos 100 by an early sync; new header with ptr=5.
    send_pkt(13'h1000, 0, 2'b01, 4'd7, 8'h3C, -1, 8'h00, 100, 4, -1, 0, 8'h99);
    send_pkt(13'h1000, 1, 2'b01, 4'd8, 8'd5, -1, 8'h00, 188, 10, 10, 0, 8'hAA);
    drain("p9_drain");
    chk("p9_syncerr", se_cnt, 1);
    chk("p9_ccerr_cnt", cc_cnt, 1);
    chk("p9_starts", start_cnt, 4);

    // Reset in the middle of a gapped payload.
    send_pkt(13'h1000, 0, 2'b01, 4'd9, 8'h0F, -1, 8'h00, 60, 4, -1, 1, 8'hBB);
    @(posedge CLK);
    #1;
    chk("pre_rst_ena", int'(ENA_OUT), 1);
    #1 RST = 1'b0;
    #1;
    chk("midrst_ena", int'(ENA_OUT), 0);
    chk("midrst_data", int'(DATA_OUT), 0);
    chk("midrst_start", int'(START_OUT), 0);
    chk("midrst_state", int'(state_mon), 0);
    sbq.delete();
    idle(3);
    RST = 1'b1;
    idle(2);

    // After reset any CC is accepted; ptr=0 starts immediately.
    send_pkt(13'h1000, 1, 2'b01, 4'd12, 8'd0, -1, 8'h00, 188, 5, 5, 0, 8'hCC);
    drain("p11_drain");
    chk("p11_ccerr_cnt", cc_cnt, 1);
    chk("p11_starts", start_cnt, 5);

    // Oversized AFC=11 adaptation field: silent discard and unlock.
    send_pkt(13'h1000, 0, 2'b11, 4'd13, 8'd183, -1, 8'h00, 188, 188, -1, 0, 8'hDD);
    drain("p14_drain");
    send_pkt(13'h1000, 0, 2'b01, 4'd14, 8'h00, -1, 8'h00, 188, 188, -1, 0, 8'hEE);
    drain("p15_drain");
    chk("p15_syncerr", se_cnt, 1);
    chk("p15_ccerr_cnt", cc_cnt, 1);

    // Missing sync after a full packet, then a sync flag on a wrong byte.
    put(8'h55, 0, 0, 0);
    idle(2);
    #1;
    chk("nosync_err", se_cnt, 2);
    put(8'h00, 1, 0, 0);
    idle(2);
    #1;
    chk("badsync_err", se_cnt, 3);
    chk("badsync_state", int'(state_mon), 0);

    // Recovery with a fresh pointer.
    send_pkt(13'h1000, 1, 2'b01, 4'd15, 8'd2, -1, 8'h00, 188, 7, 7, 0, 8'h12);
    drain("p16_drain");
    chk("p16_starts", start_cnt, 6);
    chk("p16_ccerr_cnt", cc_cnt, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout actual=running required=finished");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/t2mi_ts_extractor.md
Name: t2mi_ts_extractor

Overview:
- Receive-side counterpart of the T2-MI-over-TS packer.
- Parses a 188-byte TS byte stream and keeps only packets whose PID equals t2mi_pid.
- Handles the header, adaptation field and pointer field, and checks the continuity counter.
- Outputs the reassembled T2-MI byte stream, marking the first byte of each T2-MI packet. Feeds the T2-MI packet parser on the modulator input path.

Parameters:
SYNC_BYTE, 8'h47, value required at every PSYNC_IN byte
TS_LEN, 188, TS packet length in bytes

Ports:
CLK  in  1  clock
RST  in  1  reset, asynchronous, active-low
DATA_IN  in  8  TS byte
ENA_IN  in  1  DATA_IN valid; all parsing advances only on ENA_IN=1
PSYNC_IN  in  1  marks byte 0 of a TS packet; meaningful only with ENA_IN=1
t2mi_pid  in  13  PID carrying T2-MI; sampled at header byte 2
DATA_OUT  out  8  T2-MI byte
ENA_OUT  out  1  DATA_OUT valid
START_OUT  out  1  with ENA_OUT: first byte of a T2-MI packet
CC_ERR  out  1  one-cycle pulse on continuity error
SYNC_ERR  out  1  one-cycle pulse on framing error
state_mon  out  4  current state code

Behaviour:
- Reset (RST low, asynchronous):
  - All outputs are 0; state is WAIT_SYNC.
  - Flags are cleared: locked=0, cc_valid=0, byte position pos=0.
  - Assertion mid-packet abandons that packet completely.
- Latency: every output is registered. DATA_OUT/ENA_OUT/START_OUT appear exactly 1 cycle after the accepted input byte. Gaps in ENA_IN produce matching gaps in ENA_OUT.
- pos counts 0..TS_LEN-1 within a packet and is set to 1 after the sync byte.
- States (state_mon code):
  - WAIT_SYNC(0): wait for ENA_IN & PSYNC_IN & DATA_IN==SYNC_BYTE, then go to HDR.
  - HDR(1), header bytes 1..3:
    - Byte 1 latches TEI, PUSI and PID[12:8].
    - Byte 2 latches PID[7:0].
    - Byte 3 latches scrambling, AFC and CC.
    - At byte 3 the packet is judged:
      - PID mismatch, TEI=1, scrambling!=0 or AFC=00: go to SKIP. For TEI, also set locked=0.
      - AFC bit5=1: go to AF_LEN.
      - Else if PUSI: go to POINTER.
      - Else: go to PAYLOAD.
  - AF_LEN(2):
    - AFC=11 with af_len>182: SYNC_ERR-free discard, locked=0, go to SKIP.
    - AFC=10 (no payload): go to SKIP; CC is not checked and not advanced.
    - af_len=0: go to POINTER or PAYLOAD per PUSI.
    - Otherwise go to AF_SKIP.
  - AF_SKIP(3): drop af_len bytes, then go to POINTER or PAYLOAD.
  - POINTER(4):
    - Latch ptr and set remain=TS_LEN-1-pos.
    - ptr>=remain: locked=0, go to SKIP (pointer error, no output).
    - Otherwise go to PAYLOAD.
  - PAYLOAD(5):
    - Bytes before offset ptr are continuation bytes; they are output only if locked=1.
    - The byte at offset ptr is output with START_OUT=1 and sets locked=1; all later bytes are output.
    - With no PUSI, every byte is output if locked=1.
    - After pos==TS_LEN-1, go to WAIT_SYNC.
  - SKIP(6): consume bytes to pos==TS_LEN-1, then go to WAIT_SYNC.
- Continuity (matching PID, AFC bit4=1, TEI=0):
  - cc_valid=0: accept any CC and set cc_valid=1.
  - CC==last_cc+1 (mod 16): OK.
  - Any other value: CC_ERR pulse in the cycle after header byte 3, and locked=0 so continuation bytes are dropped until the next pointer.
  - last_cc always updates to the received CC.
- Framing errors:
  - PSYNC_IN with DATA_IN!=SYNC_BYTE: SYNC_ERR pulse, locked=0, go to WAIT_SYNC.
  - PSYNC_IN arriving while pos!=0 (early sync): SYNC_ERR pulse, locked=0, restart HDR from that byte.
  - pos reaching TS_LEN with no PSYNC_IN on the next byte: SYNC_ERR pulse, go to WAIT_SYNC.
- Simultaneous CC error and PUSI: CC_ERR fires and continuation bytes are suppressed. The new T2-MI packet at offset ptr is still output with START_OUT.

Test Plan:
- Reset, then PID 0x1000, t2mi_pid=0x1000, PUSI=1, AFC=01, CC=0, ptr=10 -> 10 bytes dropped (not locked); next byte START_OUT=1; 173 bytes out; no CC_ERR.
- Follow with PUSI=0, AFC=01, CC=1 -> 184 bytes out, START_OUT=0 throughout, DATA_OUT matches payload byte-for-byte with 1-cycle latency.
- Next packet CC=3 with PUSI=1, ptr=20 -> CC_ERR single pulse; first 20 bytes suppressed; START_OUT on byte 21; 163 bytes out.
- AFC=11, af_len=0, PUSI=0, CC sequential -> 183 bytes out. Then AFC=10, af_len=183 -> no output and CC not advanced, so the next CC=+1 packet is error-free.
- Interleave a PID 0x0000 packet, then PSYNC_IN at pos 100 of a T2-MI packet -> PID 0 gives no ENA_OUT; early sync pulses SYNC_ERR, the new header parses, locked=0.
- RST low mid-PAYLOAD, with ENA_IN gaps of 1–3 cycles before reset -> outputs 0 immediately, state_mon=0; the first post-reset packet accepts any CC without CC_ERR.
